// File: rtl/logic_gate_n_input_seq.sv
`default_nettype none
// ============================================================================
//  Module      : logic_gate_n_input_seq
//  Description : Registered N-input gate (AND/NAND/OR/NOR/XOR/XNOR) with an
//                on-chip exhaustive self-test sweep that counts '1' results.
//  Revision    : 1.0  initial release
// ============================================================================
module logic_gate_n_input_seq #(
    parameter int N_IN        = 3,
    parameter int HOLD_CYCLES = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [N_IN-1:0] din,
    input  logic            din_valid,
    input  logic [2:0]      op_sel,
    input  logic            sweep_start,
    output logic            dout,
    output logic            dout_valid,
    output logic            sweep_busy,
    output logic            sweep_done,
    output logic [N_IN-1:0] sweep_pattern,
    output logic [N_IN:0]   ones_count
);

    localparam int C_HOLD_W = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [C_HOLD_W-1:0] C_HOLD_LAST = C_HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [N_IN-1:0]     C_PAT_LAST  = '1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SWEEP = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_next;
    logic [2:0]            r_op_lat;
    logic [C_HOLD_W-1:0]   r_hold_cnt;
    logic                  w_hold_end;
    logic                  w_last_pat;
    logic                  w_sweep_bit;
    logic                  w_din_bit;

    // Codes 6 and 7 fall through to NAND.
    function automatic logic gate_f(input logic [2:0] op, input logic [N_IN-1:0] v);
        case (op)
            3'd0:    return &v;
            3'd2:    return |v;
            3'd3:    return ~|v;
            3'd4:    return ^v;
            3'd5:    return ~^v;
            default: return ~&v;
        endcase
    endfunction

    assign w_hold_end  = (r_hold_cnt == C_HOLD_LAST);
    assign w_last_pat  = (sweep_pattern == C_PAT_LAST);
    assign w_sweep_bit = gate_f(r_op_lat, sweep_pattern);
    assign w_din_bit   = gate_f(op_sel, din);
    assign sweep_busy  = (r_state == S_SWEEP);
    assign sweep_done  = (r_state == S_DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (sweep_start) w_state_next = S_SWEEP;
            S_SWEEP: if (w_hold_end && w_last_pat) w_state_next = S_DONE;
            S_DONE:  w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout          <= 1'b0;
            dout_valid    <= 1'b0;
            sweep_pattern <= '0;
            ones_count    <= '0;
            r_op_lat      <= 3'd0;
            r_hold_cnt    <= '0;
        end else begin
            dout_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    // A sweep request wins; the concurrent din sample is dropped.
                    if (sweep_start) begin
                        r_op_lat      <= op_sel;
                        sweep_pattern <= '0;
                        ones_count    <= '0;
                        r_hold_cnt    <= '0;
                    end else if (din_valid) begin
                        dout       <= w_din_bit;
                        dout_valid <= 1'b1;
                    end
                end
                S_SWEEP: begin
                    if (w_hold_end) begin
                        dout       <= w_sweep_bit;
                        dout_valid <= 1'b1;
                        ones_count <= ones_count + {{N_IN{1'b0}}, w_sweep_bit};
                        r_hold_cnt <= '0;
                        if (!w_last_pat) begin
                            sweep_pattern <= sweep_pattern + 1'b1;
                        end
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_logic_gate_n_input_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_logic_gate_n_input_seq
//  Description : Self-checking bench; three builds (3/1, 3/2, 4/1) share stimulus.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_logic_gate_n_input_seq;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] din = '0;
    logic       din_valid = 1'b0;
    logic [2:0] op_sel = '0;
    logic       sweep_start = 1'b0;
    int         sel = 0;

    logic       d0_dout, d0_dv, d0_busy, d0_done;
    logic [2:0] d0_pat;
    logic [3:0] d0_ones;
    logic       d1_dout, d1_dv, d1_busy, d1_done;
    logic [2:0] d1_pat;
    logic [3:0] d1_ones;
    logic       d2_dout, d2_dv, d2_busy, d2_done;
    logic [3:0] d2_pat;
    logic [4:0] d2_ones;

    logic       o_dout, o_dv, o_busy, o_done;
    logic [3:0] o_pat;
    logic [4:0] o_ones;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    logic_gate_n_input_seq #(.N_IN(3), .HOLD_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .din(din[2:0]), .din_valid(din_valid),
        .op_sel(op_sel), .sweep_start(sweep_start && sel == 0),
        .dout(d0_dout), .dout_valid(d0_dv), .sweep_busy(d0_busy),
        .sweep_done(d0_done), .sweep_pattern(d0_pat), .ones_count(d0_ones));

    logic_gate_n_input_seq #(.N_IN(3), .HOLD_CYCLES(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .din(din[2:0]), .din_valid(din_valid),
        .op_sel(op_sel), .sweep_start(sweep_start && sel == 1),
        .dout(d1_dout), .dout_valid(d1_dv), .sweep_busy(d1_busy),
        .sweep_done(d1_done), .sweep_pattern(d1_pat), .ones_count(d1_ones));

    logic_gate_n_input_seq #(.N_IN(4), .HOLD_CYCLES(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
        .op_sel(op_sel), .sweep_start(sweep_start && sel == 2),
        .dout(d2_dout), .dout_valid(d2_dv), .sweep_busy(d2_busy),
        .sweep_done(d2_done), .sweep_pattern(d2_pat), .ones_count(d2_ones));

    always_comb begin
        o_dout = d0_dout; o_dv = d0_dv; o_busy = d0_busy; o_done = d0_done;
        o_pat  = {1'b0, d0_pat}; o_ones = {1'b0, d0_ones};
        if (sel == 1) begin
            o_dout = d1_dout; o_dv = d1_dv; o_busy = d1_busy; o_done = d1_done;
            o_pat  = {1'b0, d1_pat}; o_ones = {1'b0, d1_ones};
        end else if (sel == 2) begin
            o_dout = d2_dout; o_dv = d2_dv; o_busy = d2_busy; o_done = d2_done;
            o_pat  = d2_pat; o_ones = d2_ones;
        end
    end

    // Reference gate: decided from the number of set bits among n inputs.
    function automatic logic ref_gate(input logic [2:0] op, input int n, input int v);
        int ones;
        ones = 0;
        for (int i = 0; i < n; i++) ones += (v >> i) & 1;
        case (op)
            3'd0:    return ones == n;
            3'd2:    return ones > 0;
            3'd3:    return ones == 0;
            3'd4:    return (ones % 2) == 1;
            3'd5:    return (ones % 2) == 0;
            default: return ones != n;
        endcase
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_dout"}, int'(o_dout), 0);
        chk({tag, "_dv"},   int'(o_dv),   0);
        chk({tag, "_busy"}, int'(o_busy), 0);
        chk({tag, "_done"}, int'(o_done), 0);
        chk({tag, "_pat"},  int'(o_pat),  0);
        chk({tag, "_ones"}, int'(o_ones), 0);
    endtask

    task automatic run_sweep(input int s, input logic [2:0] op, input bit disturb);
        int n, h, npat, idx, cyc, busy_cnt, exp_ones;
        bit seen_done;
        n = (s == 2) ? 4 : 3;
        h = (s == 1) ? 2 : 1;
        npat = 1 << n;
        exp_ones = 0;
        for (int p = 0; p < npat; p++) exp_ones += int'(ref_gate(op, n, p));
        sel = s; op_sel = op; din = 4'($urandom);
        sweep_start = 1'b1; din_valid = 1'b1;
        tick();
        sweep_start = 1'b0; din_valid = 1'b0;
        chk("start_busy",  int'(o_busy), 1);
        chk("start_no_dv", int'(o_dv),   0);
        chk("start_pat",   int'(o_pat),  0);
        chk("start_ones",  int'(o_ones), 0);
        idx = 0; cyc = 0; busy_cnt = 1; seen_done = 1'b0;
        while (!seen_done && cyc < 300) begin
            if (disturb) begin
                op_sel = 3'($urandom); din_valid = 1'($urandom);
                sweep_start = 1'($urandom); din = 4'($urandom);
            end
            tick();
            cyc++;
            if (o_busy) busy_cnt++;
            if (o_dv) begin
                chk("sweep_dout", int'(o_dout), int'(ref_gate(op, n, idx)));
                chk("pulse_time", cyc, (idx + 1) * h);
                chk("sweep_pat", int'(o_pat), (idx == npat - 1) ? idx : idx + 1);
                idx++;
            end
            if (o_done) begin
                seen_done = 1'b1;
                chk("done_with_dv", int'(o_dv), 1);
            end
        end
        chk("sweep_timeout", int'(seen_done), 1);
        chk("pulses", idx, npat);
        chk("busy_cycles", busy_cnt, npat * h);
        chk("ones", int'(o_ones), exp_ones);
        chk("final_pat", int'(o_pat), npat - 1);
        // Requests arriving in DONE must be ignored.
        sweep_start = 1'b1; din_valid = 1'b1;
        tick();
        sweep_start = 1'b0; din_valid = 1'b0; op_sel = op;
        chk("after_busy", int'(o_busy), 0);
        chk("after_done", int'(o_done), 0);
        chk("after_dv",   int'(o_dv),   0);
        chk("hold_ones",  int'(o_ones), exp_ones);
        tick();
        chk("idle_stays", int'(o_busy), 0);
    endtask

    initial begin
        logic exp_dout;
        int wait_cyc;

        #2;
        chk_all_zero("reset");
        tick();
        chk_all_zero("reset_clk");
        rst_n = 1'b1;
        tick();
        chk("idle_no_dv", int'(o_dv), 0);

        // Directed NAND in normal mode
        op_sel = 3'd1; din = 4'b0111; din_valid = 1'b1;
        tick();
        chk("nand111_dout", int'(o_dout), 0);
        chk("nand111_dv",   int'(o_dv),   1);
        din = 4'b0011;
        tick();
        chk("nand011_dout", int'(o_dout), 1);
        din_valid = 1'b0; din = 4'b0111;
        tick();
        chk("novalid_dv",   int'(o_dv),   0);
        chk("novalid_hold", int'(o_dout), 1);
        exp_dout = 1'b1;

        for (int i = 0; i < 40; i++) begin
            op_sel = 3'($urandom); din = 4'($urandom); din_valid = 1'($urandom);
            if (din_valid) exp_dout = ref_gate(op_sel, 3, int'(din[2:0]));
            tick();
            chk("rand_dv",   int'(o_dv),   int'(din_valid));
            chk("rand_dout", int'(o_dout), int'(exp_dout));
        end
        din_valid = 1'b0;
        tick();

        run_sweep(0, 3'd1, 1'b0);
        run_sweep(0, 3'd4, 1'b0);
        run_sweep(0, 3'd3, 1'b0);
        run_sweep(0, 3'd1, 1'b1);
        run_sweep(0, 3'($urandom), 1'b1);
        run_sweep(1, 3'd1, 1'b0);
        run_sweep(2, 3'd1, 1'b0);
        run_sweep(2, 3'($urandom), 1'b1);

        // Asynchronous reset in the middle of a NAND sweep
        sel = 0; op_sel = 3'd1; sweep_start = 1'b1;
        tick();
        sweep_start = 1'b0;
        wait_cyc = 0;
        while (o_pat != 4'd4 && wait_cyc < 50) begin
            tick();
            wait_cyc++;
        end
        chk("reach_pat4", int'(o_pat), 4);
        #2 rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk_all_zero("post_reset");
        run_sweep(0, 3'd1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
